// File: rtl/alu_8bit_if.sv
// ---------------------------------------------------------------------------
// alu_8bit_if
// Bundles the operand/opcode request and the registered result/flag response
// of alu_8bit.
//
// Handshake: a request is taken on every rising clk edge where in_valid = 1.
// There is no ready/backpressure; the ALU accepts one operation per cycle.
// out_valid is high for exactly the cycle after an accepted request, and
// result/Cout/zero/ovf keep their last values while out_valid is low.
//
// Signals:
//   A, B      WIDTH  operands (unsigned or two's complement)
//   Cin       1      carry-in, used only by ADD
//   op        2      00 AND, 01 OR, 10 ADD, 11 XOR
//   in_valid  1      request valid this cycle
//   result    WIDTH  registered operation result
//   Cout      1      registered carry-out
//   zero      1      registered result == 0 flag
//   ovf       1      registered signed-overflow flag
//   out_valid 1      registered response valid
//
// Modports: master drives requests (bench / upstream), slave is the ALU.
// ---------------------------------------------------------------------------
interface alu_8bit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [1:0]       op;
    logic             in_valid;
    logic [WIDTH-1:0] result;
    logic             Cout;
    logic             zero;
    logic             ovf;
    logic             out_valid;

    modport master (
        output A, B, Cin, op, in_valid,
        input  result, Cout, zero, ovf, out_valid
    );

    modport slave (
        input  A, B, Cin, op, in_valid,
        output result, Cout, zero, ovf, out_valid
    );
endinterface

// File: rtl/alu_8bit.sv
// ---------------------------------------------------------------------------
// alu_8bit
// Single-stage registered ALU: AND / OR / ADD-with-carry / XOR. The operation
// is computed combinationally from the interface inputs and captured into the
// output registers on the rising edge where in_valid is high. When in_valid is
// low the result and flags hold and out_valid drops.
//
// Ports:
//   clk    input  sole clock, rising edge
//   rst_n  input  asynchronous active-low reset (release expected to be
//                 synchronous to clk)
//   bus    slave  alu_8bit_if: A, B, Cin, op, in_valid in;
//                 result, Cout, zero, ovf, out_valid out
//
// Reset values: result 0, Cout 0, ovf 0, out_valid 0, zero 1 (consistent with
// result == 0).
// ---------------------------------------------------------------------------
module alu_8bit #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_8bit_if.slave   bus
);
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam int MSB = WIDTH - 1;

    // WIDTH+1-bit sum so the carry-out falls out as the top bit.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nxt_result;
    logic             nxt_cout;
    logic             nxt_ovf;

    assign sum = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.Cin};

    always_comb begin
        nxt_result = '0;
        nxt_cout   = 1'b0;
        nxt_ovf    = 1'b0;
        case (bus.op)
            OP_AND: nxt_result = bus.A & bus.B;
            OP_OR:  nxt_result = bus.A | bus.B;
            OP_ADD: begin
                nxt_result = sum[WIDTH-1:0];
                nxt_cout   = sum[WIDTH];
                // Signed overflow: operands share a sign the result does not.
                nxt_ovf    = (bus.A[MSB] == bus.B[MSB]) &&
                             (sum[MSB] != bus.A[MSB]);
            end
            OP_XOR: nxt_result = bus.A ^ bus.B;
            default: begin
                nxt_result = '0;
                nxt_cout   = 1'b0;
                nxt_ovf    = 1'b0;
            end
        endcase
    end

    // Output registers are the only state. The combinational result above is
    // only looked at when in_valid is high, so junk operands on idle cycles
    // never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.result    <= '0;
            bus.Cout      <= 1'b0;
            bus.zero      <= 1'b1;
            bus.ovf       <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            bus.result    <= nxt_result;
            bus.Cout      <= nxt_cout;
            bus.zero      <= (nxt_result == '0);
            bus.ovf       <= nxt_ovf;
            bus.out_valid <= 1'b1;
        end else begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_8bit.sv
// ---------------------------------------------------------------------------
// tb_alu_8bit
// Self-checking bench for alu_8bit (WIDTH = 8). Expected responses come from a
// reference model written with integer arithmetic, pushed to exp_q when a
// request is driven and popped when the response is due one edge later.
// ---------------------------------------------------------------------------
module tb_alu_8bit;
    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_8bit_if #(.WIDTH(W)) bus ();

    alu_8bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    // Packed as {result, Cout, zero, ovf}.
    logic [W+2:0] exp_q[$];
    logic [W+2:0] last_exp;
    localparam logic [W+2:0] RESET_EXP = {{W{1'b0}}, 1'b0, 1'b1, 1'b0};

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic [1:0] op);
        logic [W-1:0] r;
        logic         c;
        logic         v;
        int           s;
        int           ss;
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            2'b00: r = a & b;
            2'b01: r = a | b;
            2'b10: begin
                s  = int'(a) + int'(b) + int'(cin);
                r  = s[W-1:0];
                c  = (s >= (1 << W));
                ss = int'($signed(a)) + int'($signed(b)) + int'(cin);
                v  = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
            end
            default: r = a ^ b;
        endcase
        return {r, c, (r == '0), v};
    endfunction

    task automatic check_outputs(input string tag, input logic [W+2:0] e, input logic ov);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        check({tag, ".result"},    32'(bus.result),    32'(e[W+2:3]));
        check({tag, ".Cout"},      32'(bus.Cout),      32'(e[2]));
        check({tag, ".zero"},      32'(bus.zero),      32'(e[1]));
        check({tag, ".ovf"},       32'(bus.ovf),       32'(e[0]));
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge: drive, cross one rising edge, sample
    // 1 time unit later, then return aligned to the next falling edge.
    task automatic do_cycle(input string tag, input logic v, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic cin, input logic [1:0] op);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
        bus.op       = op;
        if (v) exp_q.push_back(model(a, b, cin, op));
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) last_exp = exp_q.pop_front();
        check_outputs(tag, last_exp, v);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.Cin      = 1'b0;
        bus.op       = 2'b00;
        last_exp     = RESET_EXP;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset", RESET_EXP, 1'b0);
        rst_n = 1'b1;

        // Directed cases
        do_cycle("and",        1'b1, 8'hAA, 8'hCC, 1'b0, 2'b00);
        do_cycle("or",         1'b1, 8'hAA, 8'hCC, 1'b1, 2'b01);
        do_cycle("add",        1'b1, 8'h0F, 8'h01, 1'b0, 2'b10);
        do_cycle("add_ovf",    1'b1, 8'h7F, 8'h01, 1'b0, 2'b10);
        do_cycle("add_cin",    1'b1, 8'hFF, 8'h01, 1'b1, 2'b10);
        do_cycle("add_wrap",   1'b1, 8'hFF, 8'h01, 1'b0, 2'b10);
        do_cycle("add_negovf", 1'b1, 8'h80, 8'h80, 1'b0, 2'b10);
        do_cycle("add_cin_ovf",1'b1, 8'h7F, 8'h00, 1'b1, 2'b10);
        do_cycle("xor",        1'b1, 8'hAA, 8'hAA, 1'b1, 2'b11);
        do_cycle("hold",       1'b0, 8'h55, 8'h0F, 1'b1, 2'b10);
        do_cycle("hold_x",     1'b0, 'x,    'x,    1'bx, 2'bxx);
        do_cycle("or_after",   1'b1, 8'h00, 8'h00, 1'b1, 2'b01);
        do_cycle("and_nocin",  1'b1, 8'hF0, 8'h3C, 1'b1, 2'b00);

        // Random traffic with occasional idle cycles
        for (int i = 0; i < 1000; i++) begin
            do_cycle("rand", ($urandom_range(0, 9) != 0),
                     W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            if (i == 500) begin
                // Mid-stream reset between edges: drive a request, then
                // assert reset before its edge.
                bus.in_valid = 1'b1;
                bus.A = 8'h12; bus.B = 8'h34; bus.op = 2'b01;
                #2;
                rst_n = 1'b0;
                #1;
                check_outputs("rst_mid", RESET_EXP, 1'b0);
                @(posedge clk);
                #1;
                check_outputs("rst_hold", RESET_EXP, 1'b0);
                @(negedge clk);
                rst_n    = 1'b1;
                exp_q.delete();
                last_exp = RESET_EXP;
                do_cycle("post_rst", 1'b1, 8'h80, 8'h7F, 1'b1, 2'b10);
            end
        end

        do_cycle("final_idle", 1'b0, 8'h00, 8'h00, 1'b0, 2'b00);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/alu_8bit.md
ALU_8BIT -- requirements
Module: alu_8bit

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be legal for any value >= 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; SHALL deassert synchronously to clk.
REQ-004 A  input  WIDTH  operand A, unsigned or two's complement.
REQ-005 B  input  WIDTH  operand B, unsigned or two's complement.
REQ-006 Cin  input  1  carry-in; SHALL be used only by ADD.
REQ-007 op  input  2  opcode: 00 AND, 01 OR, 10 ADD, 11 XOR.
REQ-008 in_valid  input  1  operands and opcode valid this cycle.
REQ-009 result  output  WIDTH  registered operation result.
REQ-010 Cout  output  1  registered carry-out.
REQ-011 zero  output  1  registered flag, result == 0.
REQ-012 ovf  output  1  registered signed-overflow flag.
REQ-013 out_valid  output  1  registered; result/flags valid.

Function
REQ-014 AND: result SHALL be A & B bitwise; Cout = 0; ovf = 0.
REQ-015 OR: result SHALL be A | B bitwise; Cout = 0; ovf = 0.
REQ-016 ADD: {Cout, result} SHALL equal the (WIDTH+1)-bit sum A + B + Cin; no saturation; wrap modulo 2^WIDTH.
REQ-017 ADD: ovf SHALL be 1 when A[MSB] == B[MSB] and result[MSB] != A[MSB], else 0.
REQ-018 XOR: result SHALL be A ^ B bitwise; Cout = 0; ovf = 0.
REQ-019 Cin SHALL be ignored for opcodes 00, 01, 11.
REQ-020 zero SHALL be 1 when the registered result is all zeros, for every opcode; it SHALL NOT consider Cout.
REQ-021 Latency: with in_valid = 1 at rising edge N, result, Cout, zero, ovf SHALL reflect that cycle's inputs after edge N, and out_valid SHALL be 1 after edge N.
REQ-022 With in_valid = 0 at an edge, result, Cout, zero and ovf SHALL hold their previous values, and out_valid SHALL be 0 after that edge.
REQ-023 Back-to-back in_valid SHALL be accepted every cycle at full throughput; no backpressure input exists.
REQ-024 No internal state other than the output registers; the operation datapath SHALL be purely combinational from registered-stage inputs.
REQ-025 X/Z on inputs while in_valid = 0 SHALL NOT affect outputs.

Reset
REQ-026 While rst_n = 0, result SHALL be 0, Cout 0, ovf 0, out_valid 0, and zero 1, taking effect immediately without a clock edge.
REQ-027 Reset asserted mid-stream SHALL discard any in-flight operation; the first operation after release SHALL be captured on the first rising edge with rst_n = 1 and in_valid = 1.

Verification
REQ-028 AND: op=00, A=8'hAA, B=8'hCC, Cin=0, in_valid=1 -> next cycle result=8'h88, Cout=0, zero=0, ovf=0, out_valid=1.
REQ-029 OR: op=01, A=8'hAA, B=8'hCC -> result=8'hEE, Cout=0, zero=0.
REQ-030 ADD: op=10, A=8'h0F, B=8'h01, Cin=0 -> result=8'h10, Cout=0, ovf=0; and A=8'h7F, B=8'h01, Cin=0 -> result=8'h80, ovf=1, Cout=0.
REQ-031 ADD with carry: op=10, A=8'hFF, B=8'h01, Cin=1 -> result=8'h01, Cout=1, zero=0, ovf=0; and A=8'hFF, B=8'h01, Cin=0 -> result=8'h00, Cout=1, zero=1.
REQ-032 XOR and hold: op=11, A=8'hAA, B=8'hAA, Cin=1 -> result=8'h00, zero=1, Cout=0; then in_valid=0 with new operands -> result held, out_valid=0.
REQ-033 Random and reset: 1000 random A/B/Cin/op compared against a reference model each cycle; assert rst_n=0 between edges mid-stream -> outputs go to reset values immediately, with no clock edge.
